// File: rtl/tfmbs_pkg.sv
// Shared constants and types for the ternary frame fetcher.
// TFMBS_PT5_DECODE_EN selects 10-bit trit-vector stream payloads instead of raw bytes.
package tfmbs_pkg;
    localparam int          PT5_TRITS = 5;
    localparam int unsigned PT5_MAX   = 243;
    localparam int          PT5_W     = 2 * PT5_TRITS;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;

`ifdef TFMBS_PT5_DECODE_EN
    localparam int OUT_W = PT5_W;
`else
    localparam int OUT_W = 8;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/ternary_frame_fetcher_if.sv
// Paired weight/input beat stream from the fetcher to the compute fabric.
// Payload width follows tfmbs_pkg::OUT_W (TFMBS_PT5_DECODE_EN widens it to 10).
interface ternary_frame_fetcher_if #(
    parameter int W = tfmbs_pkg::OUT_W
);
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_weight;
    logic [W-1:0] m_input;
    logic         m_last;
    logic         m_err;

    modport master (output m_valid, m_weight, m_input, m_last, m_err, input m_ready);
    modport slave  (input m_valid, m_weight, m_input, m_last, m_err, output m_ready);
endinterface

// File: rtl/pt5_unpacker.sv
// Unpacks one PT-5 byte into five 2-bit trits; bytes >= 243 give zero trits and err.
// Instantiated by the fetcher only when TFMBS_PT5_DECODE_EN is defined.
module pt5_unpacker
    import tfmbs_pkg::*;
(
    input  logic [7:0]       byte_in,
    output logic [PT5_W-1:0] trits,
    output logic             err
);
    always_comb begin
        int unsigned v;
        v     = 32'(byte_in);
        trits = '0;
        err   = (v >= PT5_MAX);
        if (!err) begin
            // base-3 digit d maps to trit d-1
            for (int i = 0; i < PT5_TRITS; i++) begin
                case (v % 3)
                    0:       trits[2*i +: 2] = TRIT_NEG;
                    1:       trits[2*i +: 2] = TRIT_ZERO;
                    default: trits[2*i +: 2] = TRIT_POS;
                endcase
                v = v / 3;
            end
        end
    end
endmodule

// File: rtl/ternary_frame_fetcher.sv
// Walks SRAM banks A/B in lockstep and streams paired bytes through a 2-entry skid FIFO.
// TFMBS_PT5_DECODE_EN: decode the FIFO head into trit vectors with an error flag.
module ternary_frame_fetcher
    import tfmbs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] dout_a,
    input  logic [DATA_WIDTH-1:0] dout_b,
    ternary_frame_fetcher_if.master m
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_a, cur_b, hold_a, hold_b;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  inflight, inflight_last;
    logic [DATA_WIDTH-1:0] fifo_a [2];
    logic [DATA_WIDTH-1:0] fifo_b [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  valid, pop, launch, fetch_ok, issue_last, finish;
    logic [2:0]            occ;

    assign valid      = (count != 2'd0);
    assign pop        = valid && m.m_ready;
    assign occ        = 3'(count) + 3'(inflight);
    // The first read goes out in the start cycle so the first beat lands two cycles later.
    assign launch     = (state == S_IDLE) && start && !abort && (len != '0);
    // A beat leaving this cycle frees its slot for the read issued now.
    assign fetch_ok   = (state == S_FETCH) && !abort && (occ < 3'd2 + 3'(pop));
    assign issue_last = launch ? (len == LEN_WIDTH'(1)) : (rem == LEN_WIDTH'(1));
    assign finish     = (state == S_DRAIN) && !inflight && (count - 2'(pop) == 2'd0);

    assign addr_a = launch ? base_a : (fetch_ok ? cur_a : hold_a);
    assign addr_b = launch ? base_b : (fetch_ok ? cur_b : hold_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cur_a         <= '0;
            cur_b         <= '0;
            hold_a        <= '0;
            hold_b        <= '0;
            rem           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_last     <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_a[i] <= '0;
                fifo_b[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Dropping inflight discards any read still on its way back.
                state    <= S_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                inflight <= 1'b0;
                count    <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else begin
                inflight <= launch || fetch_ok;
                if (launch || fetch_ok) begin
                    hold_a        <= addr_a;
                    hold_b        <= addr_b;
                    cur_a         <= addr_a + ADDR_WIDTH'(1);
                    cur_b         <= addr_b + ADDR_WIDTH'(1);
                    rem           <= (launch ? len : rem) - LEN_WIDTH'(1);
                    inflight_last <= issue_last;
                end
                if (inflight) begin
                    fifo_a[wr_ptr]    <= dout_a;
                    fifo_b[wr_ptr]    <= dout_b;
                    fifo_last[wr_ptr] <= inflight_last;
                    wr_ptr            <= !wr_ptr;
                end
                if (pop) rd_ptr <= !rd_ptr;
                count <= count + 2'(inflight) - 2'(pop);

                case (state)
                    S_IDLE: if (start) begin
                        if (len == '0) done <= 1'b1;
                        else begin
                            busy  <= 1'b1;
                            state <= issue_last ? S_DRAIN : S_FETCH;
                        end
                    end
                    S_FETCH: if (fetch_ok && issue_last) state <= S_DRAIN;
                    S_DRAIN: if (finish) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [DATA_WIDTH-1:0] head_a, head_b;
    assign head_a    = fifo_a[rd_ptr];
    assign head_b    = fifo_b[rd_ptr];
    assign m.m_valid = valid;
    assign m.m_last  = valid && fifo_last[rd_ptr];

`ifdef TFMBS_PT5_DECODE_EN
    logic [PT5_W-1:0] trits_w, trits_i;
    logic             err_w, err_i;

    pt5_unpacker u_unpack_w (.byte_in(head_a), .trits(trits_w), .err(err_w));
    pt5_unpacker u_unpack_i (.byte_in(head_b), .trits(trits_i), .err(err_i));

    assign m.m_weight = trits_w;
    assign m.m_input  = trits_i;
    assign m.m_err    = valid && (err_w || err_i);
`else
    assign m.m_weight = head_a;
    assign m.m_input  = head_b;
    assign m.m_err    = 1'b0;
`endif
endmodule
